// File: rtl/tlc_sensor_conditioner.sv
// Front end for the traffic light controller: syncs and debounces RAW_S/RAW_M, latches SD/MD until served, divides CLK into STEP.
// Latency RAW edge -> x_DEB is 2+DEB_CYCLES edges and -> SD/MD is 3+DEB_CYCLES edges; no backpressure, all outputs registered.
module tlc_sensor_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 3,
  parameter int STEP_DIV   = 8,
  parameter int STEP_W     = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       RAW_S,
  input  logic       RAW_M,
  input  logic [3:0] STATE,
  output logic       SD,
  output logic       MD,
  output logic       STEP,
  output logic       S_DEB,
  output logic       M_DEB
);

  localparam logic [CNT_W-1:0]  DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [STEP_W-1:0] DIV_LAST    = STEP_W'(STEP_DIV - 1);
  localparam logic [3:0]        SIDE_SERVED = 4'b0110;
  localparam logic [3:0]        MAIN_SERVED = 4'b1001;

  // bit 0 is the metastability flop, bit 1 the usable sample
  logic [1:0]        s_sync, m_sync;
  logic [CNT_W-1:0]  s_cnt, m_cnt, s_cnt_nxt, m_cnt_nxt;
  logic              s_deb_nxt, m_deb_nxt;
  logic [STEP_W-1:0] div_cnt, div_nxt;

  always_comb begin
    s_cnt_nxt = '0;
    s_deb_nxt = S_DEB;
    m_cnt_nxt = '0;
    m_deb_nxt = M_DEB;
    // a sample that matches the accepted level leaves the counter at zero
    if (s_sync[1] != S_DEB) begin
      if (s_cnt == DEB_LAST) s_deb_nxt = ~S_DEB;
      else                   s_cnt_nxt = s_cnt + CNT_W'(1);
    end
    if (m_sync[1] != M_DEB) begin
      if (m_cnt == DEB_LAST) m_deb_nxt = ~M_DEB;
      else                   m_cnt_nxt = m_cnt + CNT_W'(1);
    end
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + STEP_W'(1);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      s_sync  <= '0;
      m_sync  <= '0;
      s_cnt   <= '0;
      m_cnt   <= '0;
      S_DEB   <= 1'b0;
      M_DEB   <= 1'b0;
      SD      <= 1'b0;
      MD      <= 1'b0;
      div_cnt <= '0;
      STEP    <= 1'b0;
    end else begin
      s_sync  <= {s_sync[0], RAW_S};
      m_sync  <= {m_sync[0], RAW_M};
      s_cnt   <= s_cnt_nxt;
      m_cnt   <= m_cnt_nxt;
      S_DEB   <= s_deb_nxt;
      M_DEB   <= m_deb_nxt;
      // the served code wins over a still-present vehicle
      SD      <= (STATE == SIDE_SERVED) ? 1'b0 : (SD | S_DEB);
      MD      <= (STATE == MAIN_SERVED) ? 1'b0 : (MD | M_DEB);
      div_cnt <= div_nxt;
      STEP    <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: tb/tb_tlc_sensor_conditioner.sv
// Directed bench for tlc_sensor_conditioner with default parameters.
module tb_tlc_sensor_conditioner;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       RAW_S, RAW_M;
  logic [3:0] STATE;
  logic       SD, MD, STEP, S_DEB, M_DEB;

  int checks   = 0;
  int failures = 0;

  tlc_sensor_conditioner dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .RAW_S (RAW_S),
    .RAW_M (RAW_M),
    .STATE (STATE),
    .SD    (SD),
    .MD    (MD),
    .STEP  (STEP),
    .S_DEB (S_DEB),
    .M_DEB (M_DEB)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with sensors high, then side request latency
    CLR = 1'b0; RAW_S = 1'b1; RAW_M = 1'b1; STATE = 4'b0000;
    #1;
    check("rst_outs_async", {3'b0, SD, MD, STEP, S_DEB, M_DEB}, 8'h00);
    repeat (3) tick();
    check("rst_outs_held", {3'b0, SD, MD, STEP, S_DEB, M_DEB}, 8'h00);
    CLR = 1'b1; RAW_M = 1'b0;
    repeat (5) tick();
    check("s_deb_edge5", {7'b0, S_DEB}, 8'h00);
    tick();
    check("s_deb_edge6", {7'b0, S_DEB}, 8'h01);
    check("sd_edge6", {7'b0, SD}, 8'h00);
    check("step_edge6", {7'b0, STEP}, 8'h00);
    tick();
    check("sd_edge7", {7'b0, SD}, 8'h01);
    check("step_edge7", {7'b0, STEP}, 8'h01);

    // 2: two-cycle glitch rejected, six-cycle pulse accepted
    RAW_M = 1'b1;
    repeat (2) tick();
    RAW_M = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("glitch_m", {6'b0, M_DEB, MD}, 8'h00);
    end
    RAW_M = 1'b1;
    repeat (5) tick();
    check("pulse_mdeb_e5", {7'b0, M_DEB}, 8'h00);
    tick();
    check("pulse_mdeb_e6", {7'b0, M_DEB}, 8'h01);
    RAW_M = 1'b0;
    tick();
    check("pulse_md_e7", {7'b0, MD}, 8'h01);
    repeat (4) tick();
    check("pulse_mdeb_e11", {7'b0, M_DEB}, 8'h01);
    tick();
    check("pulse_mdeb_e12", {7'b0, M_DEB}, 8'h00);
    tick();
    check("md_held_after_fall", {7'b0, MD}, 8'h01);

    // 3: service clear, with and without a vehicle still present
    RAW_S = 1'b0;
    repeat (8) tick();
    check("sfall_deb", {6'b0, S_DEB, SD}, 8'h01);
    STATE = 4'b0110;
    tick();
    check("svc_clear", {7'b0, SD}, 8'h00);
    STATE = 4'b0000;
    repeat (3) tick();
    check("svc_stays_clear", {7'b0, SD}, 8'h00);
    RAW_S = 1'b1;
    repeat (7) tick();
    check("sd_reset_again", {7'b0, SD}, 8'h01);
    STATE = 4'b0110;
    tick();
    check("svc_present_1", {7'b0, SD}, 8'h00);
    tick();
    check("svc_present_2", {7'b0, SD}, 8'h00);
    STATE = 4'b0111;
    tick();
    check("svc_reassert", {7'b0, SD}, 8'h01);

    // 4: clear beats a same-cycle rise; channels independent
    STATE = 4'b0000; RAW_S = 1'b0;
    repeat (8) tick();
    STATE = 4'b0110;
    tick();
    STATE = 4'b0000;
    tick();
    check("prio_setup", {7'b0, SD}, 8'h00);
    RAW_S = 1'b1;
    repeat (5) tick();
    check("prio_sdeb_e5", {7'b0, S_DEB}, 8'h00);
    STATE = 4'b0110;
    tick();
    check("prio_sdeb_e6", {6'b0, S_DEB, SD}, 8'h02);
    tick();
    check("prio_clear_wins", {6'b0, SD, MD}, 8'h01);
    STATE = 4'b1001;
    tick();
    check("main_clear_only", {6'b0, SD, MD}, 8'h02);
    STATE = 4'b0000;
    tick();
    check("main_stays_clear", {6'b0, SD, MD}, 8'h02);

    // 6: unused state codes never clear
    RAW_M = 1'b1;
    repeat (7) tick();
    check("md_set_again", {7'b0, MD}, 8'h01);
    RAW_M = 1'b0; RAW_S = 1'b0;
    repeat (8) tick();
    check("debs_low", {6'b0, S_DEB, M_DEB}, 8'h00);
    for (int c = 10; c < 16; c++) begin
      STATE = 4'(c);
      tick();
      check("unused_code", {6'b0, SD, MD}, 8'h03);
    end
    STATE = 4'b0000;

    // 5: STEP cadence and asynchronous restart
    CLR = 1'b0;
    #1;
    check("midrun_rst_drop", {5'b0, SD, MD, STEP}, 8'h00);
    repeat (2) tick();
    CLR = 1'b1;
    check("step_cycle0", {7'b0, STEP}, 8'h00);
    for (int k = 1; k <= 24; k++) begin
      tick();
      check("step_cadence", {7'b0, STEP}, {7'b0, (k % 8) == 7});
    end
    CLR = 1'b0;
    tick();
    CLR = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("step_pre_rst", {7'b0, STEP}, {7'b0, k == 7});
    end
    CLR = 1'b0;
    #1;
    check("step_in_rst", {7'b0, STEP}, 8'h00);
    tick();
    CLR = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("step_restart", {7'b0, STEP}, {7'b0, k == 7});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
